graphics_line_sequencer: RTL

Command front end for the line-drawing engine. It round-robin arbitrates between two command requesters, each on an Avalon-ST command sink, and programs the engine's CSR slave (start, end, color) for the winning command. Writes whose value already sits in the engine's register are skipped. It then pulses engine start, waits for engine done, and acknowledges the requester. It sits between the command sources and the graphics_line CSR/start/done interface.

---
 rtl/graphics_line_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/graphics_line_sequencer.sv
// Command front end for the line engine: round-robin grants one of two command
// requesters, programs start/end/color CSRs (skipping unchanged values), starts the engine and acknowledges.
module graphics_line_sequencer #(
    parameter int CSR_ADDR_WIDTH = 2,
    parameter int CSR_DATA_WIDTH = 32,
    parameter int ADDR_START     = 0,
    parameter int ADDR_END       = 1,
    parameter int ADDR_COLOR     = 2,
    parameter int CMD_WIDTH      = 3*CSR_DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [1:0]                           cmd_valid,
    input  logic [1:0][CMD_WIDTH-1:0]            cmd_data,
    output logic [1:0]                           cmd_ready,
    output logic [1:0]                           cmd_done,
    output logic                                 mm_csr_write,
    output logic [CSR_ADDR_WIDTH-1:0]            mm_csr_address,
    output logic [CSR_DATA_WIDTH-1:0]            mm_csr_writedata,
    input  logic                                 mm_csr_waitrequest,
    output logic                                 eng_start,
    input  logic                                 eng_done,
    output logic                                 busy
);

    localparam int DW = CSR_DATA_WIDTH;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_START = CSR_ADDR_WIDTH'(ADDR_START);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_END   = CSR_ADDR_WIDTH'(ADDR_END);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_COLOR = CSR_ADDR_WIDTH'(ADDR_COLOR);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_START  = 3'd1,
        WR_END    = 3'd2,
        WR_COLOR  = 3'd3,
        START     = 3'd4,
        WAIT_DONE = 3'd5,
        ACK       = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic                   rr_q, rr_d;
    logic                   g_q, g_d;
    logic [CMD_WIDTH-1:0]   cmd_q, cmd_d;
    logic [DW-1:0]          sh_start_q, sh_start_d;
    logic [DW-1:0]          sh_end_q, sh_end_d;
    logic [DW-1:0]          sh_color_q, sh_color_d;

    logic [DW-1:0]          wr_field_s;
    logic [DW-1:0]          wr_shadow_s;
    logic [CSR_ADDR_WIDTH-1:0] wr_addr_s;
    state_t                 wr_next_s;
    logic                   grant_s;

    // Select the field, shadow, address and successor for the current write state
    always_comb begin
        wr_field_s  = cmd_q[DW-1:0];
        wr_shadow_s = sh_start_q;
        wr_addr_s   = A_START;
        wr_next_s   = WR_END;
        case (state_q)
            WR_START: begin
                wr_field_s  = cmd_q[DW-1:0];
                wr_shadow_s = sh_start_q;
                wr_addr_s   = A_START;
                wr_next_s   = WR_END;
            end
            WR_END: begin
                wr_field_s  = cmd_q[2*DW-1:DW];
                wr_shadow_s = sh_end_q;
                wr_addr_s   = A_END;
                wr_next_s   = WR_COLOR;
            end
            WR_COLOR: begin
                wr_field_s  = cmd_q[3*DW-1:2*DW];
                wr_shadow_s = sh_color_q;
                wr_addr_s   = A_COLOR;
                wr_next_s   = START;
            end
            default: begin
                wr_field_s  = cmd_q[DW-1:0];
                wr_shadow_s = sh_start_q;
                wr_addr_s   = A_START;
                wr_next_s   = IDLE;
            end
        endcase
    end

    // Next-state and output decode
    always_comb begin
        state_d          = state_q;
        rr_d             = rr_q;
        g_d              = g_q;
        cmd_d            = cmd_q;
        sh_start_d       = sh_start_q;
        sh_end_d         = sh_end_q;
        sh_color_d       = sh_color_q;
        grant_s          = 1'b0;
        cmd_ready        = 2'b00;
        cmd_done         = 2'b00;
        mm_csr_write     = 1'b0;
        mm_csr_address   = {CSR_ADDR_WIDTH{1'b0}};
        mm_csr_writedata = {DW{1'b0}};
        eng_start        = 1'b0;
        busy             = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (|cmd_valid) begin
                    grant_s   = cmd_valid[rr_q] ? rr_q : ~rr_q;
                    cmd_ready = grant_s ? 2'b10 : 2'b01;
                    cmd_d     = cmd_data[grant_s];
                    g_d       = grant_s;
                    state_d   = WR_START;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_START, WR_END, WR_COLOR: begin
                // The shadow mirrors the engine register, so an equal value needs no bus cycle
                if (wr_field_s == wr_shadow_s) begin
                    state_d = wr_next_s;
                end else begin
                    mm_csr_write     = 1'b1;
                    mm_csr_address   = wr_addr_s;
                    mm_csr_writedata = wr_field_s;
                    if (!mm_csr_waitrequest) begin
                        state_d = wr_next_s;
                        if (state_q == WR_START) begin
                            sh_start_d = wr_field_s;
                        end else if (state_q == WR_END) begin
                            sh_end_d = wr_field_s;
                        end else begin
                            sh_color_d = wr_field_s;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            START: begin
                eng_start = 1'b1;
                state_d   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (eng_done) begin
                    state_d = ACK;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            ACK: begin
                cmd_done = g_q ? 2'b10 : 2'b01;
                rr_d     = ~g_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, arbitration pointer, latched command and shadow registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            g_q        <= 1'b0;
            cmd_q      <= {CMD_WIDTH{1'b0}};
            sh_start_q <= {DW{1'b0}};
            sh_end_q   <= {DW{1'b0}};
            sh_color_q <= {DW{1'b0}};
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            g_q        <= g_d;
            cmd_q      <= cmd_d;
            sh_start_q <= sh_start_d;
            sh_end_q   <= sh_end_d;
            sh_color_q <= sh_color_d;
        end
    end

endmodule
